// File: rtl/riscv_pkg.sv
// Shared types and constants for the IF-stage branch predictor.
// Contains no logic and no storage.
// The BTB entry layout, the BHT counter width and the counter reset value live here.
package riscv_pkg;

  localparam int unsigned BHT_CTR_W = 2;
  localparam logic [BHT_CTR_W-1:0] BHT_CTR_RESET = 2'b01;

  // Tags are stored zero-extended to a fixed width so the entry type does not
  // depend on the BTB depth chosen by the instantiating module.
  localparam int unsigned BTB_TAG_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          target;
  } btb_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// One 2-bit saturating direction counter for a single BHT entry.
// Latency: a training pulse is visible on ctr_o one cycle later.
// Backpressure: none; en_i is a single-cycle training strobe.
module bp_sat_counter
  import riscv_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 inc_i,
  output logic [BHT_CTR_W-1:0] ctr_o
);

  logic [BHT_CTR_W-1:0] ctr_q;
  logic [BHT_CTR_W-1:0] ctr_d;

  // Step toward taken or not-taken, holding at either end of the range.
  always_comb begin
    ctr_d = ctr_q;
    if (en_i) begin
      if (inc_i && (ctr_q != 2'b11)) begin
        ctr_d = ctr_q + 2'b01;
      end else if (!inc_i && (ctr_q != 2'b00)) begin
        ctr_d = ctr_q - 2'b01;
      end
    end
  end

  // Counter register; reset leaves it weakly not-taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctr_q <= BHT_CTR_RESET;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign ctr_o = ctr_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB (jalr targets) plus a BHT of 2-bit counters, looked up on the fetch PC.
// Latency: lookup is combinational; table writes are visible the cycle after they are applied.
// Backpressure: none; updates from EX are accepted every cycle. A same-cycle write is not bypassed.
module branch_predictor
  import riscv_pkg::*;
#(
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned BHT_ENTRIES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pc_valid_if,
  input  logic [31:0] pc_if,
  input  logic        instr_jal_if,
  input  logic        instr_branch_if,
  input  logic [31:0] direct_target_if,
  output logic        predict_taken_if,
  output logic [31:0] predict_target_if,
  output logic        btb_hit_if,
  input  logic        btb_flush,
  input  logic        btb_update,
  input  logic        btb_invalid,
  input  logic [31:0] btb_pc,
  input  logic [31:0] btb_target,
  input  logic        bht_updata,
  input  logic [31:0] bht_pc,
  input  logic        bht_taken
);

  localparam int unsigned BTB_IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned BHT_IDX_W = $clog2(BHT_ENTRIES);

  // Zero-extended tag: everything above the halfword offset and the index.
  function automatic logic [BTB_TAG_W-1:0] tag_of(input logic [31:0] pc);
    return {{(BTB_IDX_W + 1){1'b0}}, pc[31:BTB_IDX_W+1]};
  endfunction

  btb_entry_t btb_q [BTB_ENTRIES];
  btb_entry_t btb_d [BTB_ENTRIES];

  logic [BHT_CTR_W-1:0] bht_ctr [BHT_ENTRIES];

  logic [BTB_IDX_W-1:0] lk_btb_idx;
  logic [BHT_IDX_W-1:0] lk_bht_idx;
  logic [BTB_IDX_W-1:0] up_btb_idx;
  logic [BHT_IDX_W-1:0] up_bht_idx;
  logic [BTB_TAG_W-1:0] up_tag;
  btb_entry_t           lk_ent;

  assign lk_btb_idx = pc_if[BTB_IDX_W:1];
  assign lk_bht_idx = pc_if[BHT_IDX_W:1];
  assign up_btb_idx = btb_pc[BTB_IDX_W:1];
  assign up_bht_idx = bht_pc[BHT_IDX_W:1];
  assign up_tag     = tag_of(btb_pc);
  assign lk_ent     = btb_q[lk_btb_idx];

  // PCs are halfword aligned and the BHT is untagged, so these bits carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_if[0], btb_pc[0], bht_pc[0], bht_pc[31:BHT_IDX_W+1]};

  // BTB next state: flush beats invalidate, invalidate (on tag match) beats update.
  always_comb begin
    btb_d = btb_q;
    if (btb_flush) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_d[i].valid = 1'b0;
      end
    end else if (btb_invalid && (btb_q[up_btb_idx].tag == up_tag)) begin
      btb_d[up_btb_idx].valid = 1'b0;
    end else if (btb_update) begin
      btb_d[up_btb_idx].valid  = 1'b1;
      btb_d[up_btb_idx].tag    = up_tag;
      btb_d[up_btb_idx].target = btb_target;
    end
  end

  // BTB storage as flops so that reset clears every entry at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_q[i] <= '0;
      end
    end else begin
      btb_q <= btb_d;
    end
  end

  // One saturating counter per BHT entry; only the indexed counter is trained.
  for (genvar g = 0; g < BHT_ENTRIES; g++) begin : g_bht
    bp_sat_counter u_ctr (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .en_i   (bht_updata && (up_bht_idx == BHT_IDX_W'(g))),
      .inc_i  (bht_taken),
      .ctr_o  (bht_ctr[g])
    );
  end

  // Redirect selection: BTB hit, then JAL, then the BHT counter for branches.
  always_comb begin
    btb_hit_if        = pc_valid_if && lk_ent.valid && (lk_ent.tag == tag_of(pc_if));
    predict_taken_if  = 1'b0;
    predict_target_if = direct_target_if;
    if (btb_hit_if) begin
      predict_taken_if  = 1'b1;
      predict_target_if = lk_ent.target;
    end else if (instr_jal_if) begin
      predict_taken_if  = pc_valid_if;
    end else if (instr_branch_if) begin
      predict_taken_if  = pc_valid_if && bht_ctr[lk_bht_idx][1];
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (16-entry BTB, 64-entry BHT).
// Latency: inputs are driven 1 ns after a rising edge and outputs are sampled before the next edge.
// Backpressure: not applicable; every update is applied for exactly one clock.
module tb_branch_predictor;

  logic        clk;
  logic        reset_n;
  logic        pc_valid_if;
  logic [31:0] pc_if;
  logic        instr_jal_if;
  logic        instr_branch_if;
  logic [31:0] direct_target_if;
  logic        predict_taken_if;
  logic [31:0] predict_target_if;
  logic        btb_hit_if;
  logic        btb_flush;
  logic        btb_update;
  logic        btb_invalid;
  logic [31:0] btb_pc;
  logic [31:0] btb_target;
  logic        bht_updata;
  logic [31:0] bht_pc;
  logic        bht_taken;

  int errors = 0;
  int checks = 0;

  branch_predictor #(.BTB_ENTRIES(16), .BHT_ENTRIES(64)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .pc_valid_if       (pc_valid_if),
    .pc_if             (pc_if),
    .instr_jal_if      (instr_jal_if),
    .instr_branch_if   (instr_branch_if),
    .direct_target_if  (direct_target_if),
    .predict_taken_if  (predict_taken_if),
    .predict_target_if (predict_target_if),
    .btb_hit_if        (btb_hit_if),
    .btb_flush         (btb_flush),
    .btb_update        (btb_update),
    .btb_invalid       (btb_invalid),
    .btb_pc            (btb_pc),
    .btb_target        (btb_target),
    .bht_updata        (bht_updata),
    .bht_pc            (bht_pc),
    .bht_taken         (bht_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    pc_valid_if = 1'b1; pc_if = 32'h100; instr_jal_if = 1'b0; instr_branch_if = 1'b1;
    direct_target_if = 32'h104;
    btb_flush = 1'b0; btb_update = 1'b0; btb_invalid = 1'b0; btb_pc = '0; btb_target = '0;
    bht_updata = 1'b0; bht_pc = '0; bht_taken = 1'b0;
    #2;
    checks++; if (predict_taken_if !== 1'b0) begin errors++; $display("FAIL reset_taken got=%b exp=0", predict_taken_if); end
    checks++; if (btb_hit_if !== 1'b0) begin errors++; $display("FAIL reset_hit got=%b exp=0", btb_hit_if); end
    checks++; if (predict_target_if !== 32'h104) begin errors++; $display("FAIL reset_target got=%h exp=00000104", predict_target_if); end
    tick(); tick();
    @(negedge clk); reset_n = 1'b1;
    tick();
    checks++; if (predict_taken_if !== 1'b0) begin errors++; $display("FAIL post_reset_taken got=%b exp=0", predict_taken_if); end
  endtask

  task automatic test_bht();
    // Walk from 01 up to the ceiling, down to the floor, then back up two steps.
    logic dirs [11] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
    logic exp  [11] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    pc_if = 32'h100; instr_branch_if = 1'b1; direct_target_if = 32'h140;
    bht_pc = 32'h100; bht_updata = 1'b1;
    for (int i = 0; i < 11; i++) begin
      bht_taken = dirs[i];
      tick();
      checks++;
      if (predict_taken_if !== exp[i] || predict_target_if !== 32'h140) begin
        errors++;
        $display("FAIL bht_step%0d taken=%b exp=%b target=%h exp=00000140", i, predict_taken_if, exp[i], predict_target_if);
      end
    end
    bht_updata = 1'b0;
    tick();
    pc_if = 32'h180; #1;
    checks++; if (predict_taken_if !== 1'b1) begin errors++; $display("FAIL bht_alias got=%b exp=1", predict_taken_if); end
    pc_if = 32'h102; #1;
    checks++; if (predict_taken_if !== 1'b0) begin errors++; $display("FAIL bht_neighbour got=%b exp=0", predict_taken_if); end
    pc_if = 32'h100; pc_valid_if = 1'b0; #1;
    checks++; if (predict_taken_if !== 1'b0) begin errors++; $display("FAIL bht_gated got=%b exp=0", predict_taken_if); end
    pc_valid_if = 1'b1; instr_branch_if = 1'b0;
  endtask

  task automatic test_btb();
    direct_target_if = 32'h2100; pc_if = 32'h0;
    btb_update = 1'b1; btb_pc = 32'h2004; btb_target = 32'h8000_0040;
    tick();
    btb_update = 1'b0; pc_if = 32'h2004; #1;
    checks++; if (btb_hit_if !== 1'b1) begin errors++; $display("FAIL btb_hit got=%b exp=1", btb_hit_if); end
    checks++; if (predict_taken_if !== 1'b1 || predict_target_if !== 32'h8000_0040) begin
      errors++; $display("FAIL btb_target taken=%b target=%h exp taken=1 target=80000040", predict_taken_if, predict_target_if); end
    instr_branch_if = 1'b1; #1;
    checks++; if (predict_taken_if !== 1'b1 || predict_target_if !== 32'h8000_0040) begin
      errors++; $display("FAIL btb_over_branch taken=%b target=%h exp taken=1 target=80000040", predict_taken_if, predict_target_if); end
    instr_branch_if = 1'b0;
    pc_if = 32'h3004; #1;
    checks++; if (btb_hit_if !== 1'b0 || predict_taken_if !== 1'b0 || predict_target_if !== 32'h2100) begin
      errors++; $display("FAIL btb_tag_miss hit=%b taken=%b target=%h exp hit=0 taken=0 target=00002100", btb_hit_if, predict_taken_if, predict_target_if); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    pc_if = 32'h2008; btb_update = 1'b1; btb_pc = 32'h2008; btb_target = 32'h9000_0000;
    bht_updata = 1'b1; bht_pc = 32'h102; bht_taken = 1'b1;
    #1;
    checks++; if (btb_hit_if !== 1'b0) begin errors++; $display("FAIL same_cycle_bypass got=%b exp=0", btb_hit_if); end
    tick();
    btb_update = 1'b0; bht_updata = 1'b0; #1;
    checks++; if (btb_hit_if !== 1'b1 || predict_target_if !== 32'h9000_0000) begin
      errors++; $display("FAIL same_cycle_next hit=%b target=%h exp hit=1 target=90000000", btb_hit_if, predict_target_if); end
    pc_if = 32'h102; instr_branch_if = 1'b1; #1;
    checks++; if (predict_taken_if !== 1'b1 || predict_target_if !== 32'h2100) begin
      errors++; $display("FAIL same_cycle_bht taken=%b target=%h exp taken=1 target=00002100", predict_taken_if, predict_target_if); end
    instr_branch_if = 1'b0;
  endtask

  task automatic test_inval_flush();
    btb_update = 1'b1; btb_invalid = 1'b1; btb_pc = 32'h2004; btb_target = 32'h1234;
    tick();
    btb_update = 1'b0; btb_invalid = 1'b0; pc_if = 32'h2004; #1;
    checks++; if (btb_hit_if !== 1'b0) begin errors++; $display("FAIL inval_wins got=%b exp=0", btb_hit_if); end
    btb_invalid = 1'b1; btb_pc = 32'h3008;
    tick();
    btb_invalid = 1'b0; pc_if = 32'h2008; #1;
    checks++; if (btb_hit_if !== 1'b1) begin errors++; $display("FAIL inval_tag_mismatch got=%b exp=1", btb_hit_if); end
    for (int i = 0; i < 16; i++) begin
      btb_update = 1'b1; btb_pc = 32'h5000 + 32'(2 * i); btb_target = 32'hA000 + 32'(i);
      tick();
    end
    btb_update = 1'b0; pc_if = 32'h501E; #1;
    checks++; if (btb_hit_if !== 1'b1 || predict_target_if !== 32'hA00F) begin
      errors++; $display("FAIL fill_last hit=%b target=%h exp hit=1 target=0000a00f", btb_hit_if, predict_target_if); end
    btb_flush = 1'b1; btb_update = 1'b1; btb_pc = 32'h5000; btb_target = 32'hBEEF;
    tick();
    btb_flush = 1'b0; btb_update = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pc_if = 32'h5000 + 32'(2 * i); #1;
      checks++;
      if (btb_hit_if !== 1'b0) begin errors++; $display("FAIL flush_entry%0d got=%b exp=0", i, btb_hit_if); end
    end
  endtask

  task automatic test_jal();
    pc_if = 32'h6000; instr_jal_if = 1'b1; direct_target_if = 32'h400; pc_valid_if = 1'b0; #1;
    checks++; if (predict_taken_if !== 1'b0) begin errors++; $display("FAIL jal_gated got=%b exp=0", predict_taken_if); end
    pc_valid_if = 1'b1; #1;
    checks++; if (predict_taken_if !== 1'b1 || predict_target_if !== 32'h400) begin
      errors++; $display("FAIL jal_taken taken=%b target=%h exp taken=1 target=00000400", predict_taken_if, predict_target_if); end
    btb_update = 1'b1; btb_pc = 32'h6000; btb_target = 32'h7777_0000;
    tick();
    btb_update = 1'b0; pc_valid_if = 1'b0; #1;
    checks++; if (btb_hit_if !== 1'b0 || predict_taken_if !== 1'b0) begin
      errors++; $display("FAIL btb_gated hit=%b taken=%b exp hit=0 taken=0", btb_hit_if, predict_taken_if); end
    pc_valid_if = 1'b1; #1;
    checks++; if (btb_hit_if !== 1'b1 || predict_target_if !== 32'h7777_0000) begin
      errors++; $display("FAIL btb_over_jal hit=%b target=%h exp hit=1 target=77770000", btb_hit_if, predict_target_if); end
    instr_jal_if = 1'b0;
  endtask

  task automatic test_async_reset();
    // Counter at 0x100 is 10 (taken) from the BHT test; BTB holds 0x6000.
    @(negedge clk); #2;
    reset_n = 1'b0; #1;
    pc_if = 32'h6000; #1;
    checks++; if (btb_hit_if !== 1'b0) begin errors++; $display("FAIL async_reset_btb got=%b exp=0", btb_hit_if); end
    pc_if = 32'h100; instr_branch_if = 1'b1; #1;
    checks++; if (predict_taken_if !== 1'b0) begin errors++; $display("FAIL async_reset_bht got=%b exp=0", predict_taken_if); end
    @(negedge clk); reset_n = 1'b1;
    bht_updata = 1'b1; bht_pc = 32'h100; bht_taken = 1'b1;
    tick();
    bht_updata = 1'b0; #1;
    checks++; if (predict_taken_if !== 1'b1) begin errors++; $display("FAIL after_reset_train got=%b exp=1", predict_taken_if); end
    instr_branch_if = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bht();
    test_btb();
    test_same_cycle();
    test_inval_flush();
    test_jal();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
